inst_mem_responder: RTL and testbench
=====================================

// Module: inst_mem_responder
// PURPOSE
//  Synthesizable, parametrised instruction-memory slave for the Processor InstMem_* bus.
//  Stores DEPTH words mapped at BASE_ADDR and answers each read with a one-cycle InstMem_Ack after LATENCY wait cycles.
//  Replaces hand-timed ack generation in benches and FPGA builds.
//  Flags out-of-range fetches with a bus-error pulse.
// PARAMETERS
//  ADDR_W     30         word-address width (matches InstMem_Address)
//  DATA_W     32         instruction width
//  DEPTH      1024       words stored; power of two, >= 2
//  BASE_ADDR  30'h0FF8   word address of array index 0
//  LATENCY    2          wait cycles between request capture and ack; 0..15
//  INIT_FILE  ""         $readmemh image loaded at elaboration; empty = all zero
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       asynchronous, active-low reset
//  InstMem_Address  in   ADDR_W  word address from core
//  InstMem_Read     in   1       read request, level
//  InstMem_In       out  DATA_W  instruction to core; valid only while InstMem_Ack=1
//  InstMem_Ack      out  1       one-cycle ack pulse
//  Bus_Err          out  1       one-cycle pulse, coincident with ack of an out-of-range fetch
//  Load_We          in   1       [IMEM_LOAD_PORT_EN] write strobe
//  Load_Idx         in   log2(DEPTH)  [IMEM_LOAD_PORT_EN] array index to write
//  Load_Data        in   DATA_W  [IMEM_LOAD_PORT_EN] word to write
// BEHAVIOUR
//  Reset: state=IDLE, InstMem_Ack=0, InstMem_In=0, Bus_Err=0, wait counter=0. Array contents not cleared.
//  States:
//   IDLE: Read=1 -> latch address; cnt=LATENCY; go WAIT, or go ACK if LATENCY=0.
//   WAIT: cnt decrements each cycle; Read=0 -> abort, go IDLE, no ack; cnt==1 -> go ACK.
//   ACK:  registered InstMem_Ack=1 and InstMem_In=word for exactly this cycle.
//         Read=1 here -> latch new address, start next request as from IDLE; else go IDLE.
//  Timing: Read sampled high at edge t -> Ack high during cycle t+1+LATENCY.
//   Back-to-back throughput = one word per LATENCY+1 cycles.
//  Address changes during WAIT are ignored; the latched address is served.
//  Range: idx = addr - BASE_ADDR (ADDR_W-bit modular subtraction); in range iff idx < DEPTH.
//  Out of range: ack still issued; InstMem_In = 32'h0000_0000 (NOP); Bus_Err=1 with ack.
//  Wrap: addr below BASE_ADDR wraps to a huge idx -> out of range, never aliased.
//  Array read is registered on the edge entering ACK.
//  Reset asserted mid-WAIT/ACK: immediate return to IDLE, outputs 0; pending request dropped.
// CONFIGURATION
//  `IMEM_LOAD_PORT_EN defined:
//   Load_* ports exist. Load_We writes Load_Data at Load_Idx on the clock edge.
//   A write to the index being read on the same edge -> ack returns the OLD word.
//   Writes are accepted in any state and during reset.
//  `IMEM_LOAD_PORT_EN undefined:
//   Load_* ports absent; array is ROM initialised from INIT_FILE only.
// STRUCTURE
//  imem_defs.vh: state encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2), IMEM_NOP=32'h0, counter width.
//  Sub-module imem_array: DEPTH x DATA_W storage, registered read, optional write port, INIT_FILE load.
//  Top level holds the FSM, wait counter, range check and output registers.
// TESTING
//  Reset low mid-WAIT, LATENCY=2 -> next cycle Ack=0, InstMem_In=0, state IDLE; no stale ack after release.
//  LATENCY=2, Read high at t, addr 0x0FF9, word[1]=0x20110001 -> Ack only at t+3, InstMem_In=0x20110001.
//  Read held high, addrs 0x0FF8..0x0FFB, LATENCY=2 -> four acks spaced 3 cycles apart, words in order.
//  LATENCY=0 -> Ack every cycle after t; Read dropped in WAIT (LATENCY=3) -> no ack.
//  addr 0x0FF7 and BASE_ADDR+DEPTH -> Ack with InstMem_In=0 and Bus_Err=1, same cycle.
//  With IMEM_LOAD_PORT_EN: write idx 0 = 0x08000FF8 while reading idx 0 -> old word; next read -> 0x08000FF8.

Source files
------------

// File: rtl/inst_mem_responder_pkg.sv
// Shared state encoding and constants for the inst_mem_responder instruction-memory slave.
package inst_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [31:0] IMEM_NOP = 32'h0000_0000;
   localparam int          CNT_W    = 4;

endpackage

// File: rtl/inst_mem_responder_array.sv
// DEPTH x DATA_W instruction storage with a registered read port.
// Optional load port when IMEM_LOAD_PORT_EN is defined; otherwise a ROM.
module inst_mem_responder_array
   import inst_mem_responder_pkg::*;
#(
   parameter int    DATA_W    = 32,
   parameter int    DEPTH     = 1024,
   parameter string INIT_FILE = "",
   localparam int   IDX_W     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
`ifdef IMEM_LOAD_PORT_EN
   ,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data
`endif
);

   // NOTE: the storage array has no reset; only the read register does, so a reset keeps the image.
   logic [DATA_W-1:0] mem [DEPTH];

`ifdef IMEM_LOAD_PORT_EN
   always_ff @(posedge clock) begin
      if (we) mem[wr_idx] <= wr_data;
   end
`endif

   // NOTE: non-blocking here means a same-edge load write is seen by the read as the old word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)     rd_data <= DATA_W'(IMEM_NOP);
      else if (rd_en) rd_data <= mem[rd_idx];
      else            rd_data <= DATA_W'(IMEM_NOP);
   end

endmodule

// File: rtl/inst_mem_responder.sv
// InstMem_* bus slave: request FSM, wait counter, range check and registered ack/error.
// IMEM_LOAD_PORT_EN adds the Load_* write port into the instruction array.
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int                ADDR_W    = 30,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0FF8,
   parameter int                LATENCY   = 2,
   parameter string             INIT_FILE = "",
   localparam int               IDX_W     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] InstMem_Address,
   input  logic              InstMem_Read,
   output logic [DATA_W-1:0] InstMem_In,
   output logic              InstMem_Ack,
   output logic              Bus_Err
`ifdef IMEM_LOAD_PORT_EN
   ,
   input  logic              Load_We,
   input  logic [IDX_W-1:0]  Load_Idx,
   input  logic [DATA_W-1:0] Load_Data
`endif
);

   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] fetch_off;
   logic              fire;
   logic              in_range;
   logic              ack_q;
   logic              err_q;

   // fire marks the edge that enters ACK; fetch_addr is the word served on that edge.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      fire       = 1'b0;
      fetch_addr = InstMem_Address;
      case (state)
         ST_WAIT: begin
            fire       = InstMem_Read && (cnt == CNT_W'(1));
            fetch_addr = addr_q;
         end
         ST_IDLE, ST_ACK: fire = InstMem_Read && (LATENCY == 0);
         default:         fire = 1'b0;
      endcase
      fetch_off = fetch_addr - BASE_ADDR;
      in_range  = (fetch_off < ADDR_W'(DEPTH));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         addr_q <= '0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ack_q <= fire;
         err_q <= fire && !in_range;
         case (state)
            ST_IDLE, ST_ACK: begin
               if (InstMem_Read) begin
                  addr_q <= InstMem_Address;
                  cnt    <= LAT_CNT;
                  state  <= (LATENCY == 0) ? ST_ACK : ST_WAIT;
               end else begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!InstMem_Read) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else if (cnt == CNT_W'(1)) begin
                  cnt   <= '0;
                  state <= ST_ACK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   inst_mem_responder_array #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (fire && in_range),
      .rd_idx  (fetch_off[IDX_W-1:0]),
      .rd_data (InstMem_In)
`ifdef IMEM_LOAD_PORT_EN
      ,
      .we      (Load_We),
      .wr_idx  (Load_Idx),
      .wr_data (Load_Data)
`endif
   );

   assign InstMem_Ack = ack_q;
   assign Bus_Err     = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder at LATENCY 2, 0 and 3 with BASE_ADDR 0x0FF8, DEPTH 1024.
module tb_inst_mem_responder;

   localparam logic [31:0] W0   = 32'hA000_0000;
   localparam logic [31:0] W1   = 32'h2011_0001;
   localparam logic [31:0] W2   = 32'h3C01_0002;
   localparam logic [31:0] W3   = 32'h8C22_0003;
   localparam logic [31:0] WTOP = 32'hDEAD_BEEF;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [29:0] addr;
   logic        rd2, rd0, rd3;
   logic [31:0] data2, data0, data3;
   logic        ack2, ack0, ack3;
   logic        err2, err0, err3;
   logic        load_we;
   logic [9:0]  load_idx;
   logic [31:0] load_data;
   logic [31:0] words [4];
   int          total = 0;
   int          bad   = 0;

   always #5 clock = ~clock;

   inst_mem_responder #(.LATENCY(2)) dut2 (
      .clock (clock), .reset (reset), .InstMem_Address (addr), .InstMem_Read (rd2),
      .InstMem_In (data2), .InstMem_Ack (ack2), .Bus_Err (err2)
`ifdef IMEM_LOAD_PORT_EN
      , .Load_We (load_we), .Load_Idx (load_idx), .Load_Data (load_data)
`endif
   );

   inst_mem_responder #(.LATENCY(0)) dut0 (
      .clock (clock), .reset (reset), .InstMem_Address (addr), .InstMem_Read (rd0),
      .InstMem_In (data0), .InstMem_Ack (ack0), .Bus_Err (err0)
`ifdef IMEM_LOAD_PORT_EN
      , .Load_We (load_we), .Load_Idx (load_idx), .Load_Data (load_data)
`endif
   );

   inst_mem_responder #(.LATENCY(3)) dut3 (
      .clock (clock), .reset (reset), .InstMem_Address (addr), .InstMem_Read (rd3),
      .InstMem_In (data3), .InstMem_Ack (ack3), .Bus_Err (err3)
`ifdef IMEM_LOAD_PORT_EN
      , .Load_We (load_we), .Load_Idx (load_idx), .Load_Data (load_data)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] w);
`ifdef IMEM_LOAD_PORT_EN
      load_we   = 1'b1;
      load_idx  = idx;
      load_data = w;
      tick();
      load_we   = 1'b0;
`else
      dut2.u_array.mem[idx] = w;
      dut0.u_array.mem[idx] = w;
      dut3.u_array.mem[idx] = w;
`endif
   endtask

   // Single LATENCY=2 fetch; the address bus is scrambled during WAIT to show the latched one is used.
   task automatic read2(input logic [29:0] a, input logic [31:0] d, input logic e, input string tag);
      addr = a;
      rd2  = 1'b1;
      tick();
      addr = ~a;
      check({tag, "_w1"}, ack2, 0);
      tick();
      check({tag, "_w2"}, ack2, 0);
      tick();
      check({tag, "_ack"}, ack2, 1);
      check({tag, "_data"}, data2, d);
      check({tag, "_err"}, err2, e);
      rd2 = 1'b0;
      tick();
      check({tag, "_end"}, {ack2, err2}, 0);
      check({tag, "_clr"}, data2, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      addr      = '0;
      rd2       = 1'b0;
      rd0       = 1'b0;
      rd3       = 1'b0;
      load_we   = 1'b0;
      load_idx  = '0;
      load_data = '0;
      words     = '{W0, W1, W2, W3};

      // Array is written while reset is held low.
      preload(10'd0, W0);
      preload(10'd1, W1);
      preload(10'd2, W2);
      preload(10'd3, W3);
      preload(10'd1023, WTOP);
      tick();
      check("reset_ack", {ack2, ack0, ack3}, 0);
      check("reset_data", data2, 0);
      check("reset_err", {err2, err0, err3}, 0);
      check("reset_state", dut2.state, 2'd0);
      reset = 1'b1;
      tick();

      read2(30'h0FF9, W1, 1'b0, "single");

      // Back-to-back with Read held: one ack every 3 cycles.
      addr = 30'h0FF8;
      rd2  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         addr = 30'h0FF8 + 30'(k + 1);
         check("b2b_gap1", ack2, 0);
         tick();
         check("b2b_gap2", ack2, 0);
         tick();
         check("b2b_ack", ack2, 1);
         check("b2b_data", data2, words[k]);
      end
      rd2 = 1'b0;
      tick();
      check("b2b_end", ack2, 0);

      // Reset mid-WAIT drops the pending request.
      addr = 30'h0FF9;
      rd2  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rstw_ack", ack2, 0);
      check("rstw_data", data2, 0);
      check("rstw_state", dut2.state, 2'd0);
      tick();
      check("rstw_hold", ack2, 0);
      rd2   = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rstw_after", ack2, 0);
      end

      // Reset during ACK clears outputs at once.
      addr = 30'h0FF8;
      rd2  = 1'b1;
      tick();
      tick();
      tick();
      check("rsta_ack", ack2, 1);
      check("rsta_data", data2, W0);
      reset = 1'b0;
      #1;
      check("rsta_ack_clr", ack2, 0);
      check("rsta_data_clr", data2, 0);
      rd2 = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rsta_after", ack2, 0);

      // LATENCY=0: an ack on every edge with Read high.
      check("l0_idle", ack0, 0);
      addr = 30'h0FF8;
      rd0  = 1'b1;
      tick();
      check("l0_ack0", ack0, 1);
      check("l0_data0", data0, W0);
      addr = 30'h0FF9;
      tick();
      check("l0_ack1", ack0, 1);
      check("l0_data1", data0, W1);
      addr = 30'h0FFA;
      tick();
      check("l0_ack2", ack0, 1);
      check("l0_data2", data0, W2);
      rd0 = 1'b0;
      tick();
      check("l0_end", ack0, 0);

      // LATENCY=3: full fetch, then an aborted one.
      addr = 30'h0FFB;
      rd3  = 1'b1;
      tick();
      check("l3_w1", ack3, 0);
      tick();
      check("l3_w2", ack3, 0);
      tick();
      check("l3_w3", ack3, 0);
      tick();
      check("l3_ack", ack3, 1);
      check("l3_data", data3, W3);
      rd3 = 1'b0;
      tick();
      addr = 30'h0FF9;
      rd3  = 1'b1;
      tick();
      tick();
      rd3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("l3_abort", ack3, 0);
      end

      // Range edges: below base wraps, one past the end, and the last word.
      read2(30'h0FF7, 32'h0, 1'b1, "below");
      read2(30'h13F8, 32'h0, 1'b1, "above");
      read2(30'h13F7, WTOP, 1'b0, "top");

`ifdef IMEM_LOAD_PORT_EN
      // Write to index 0 on the edge that reads it returns the old word.
      addr = 30'h0FF8;
      rd2  = 1'b1;
      tick();
      tick();
      load_we   = 1'b1;
      load_idx  = 10'd0;
      load_data = 32'h0800_0FF8;
      tick();
      load_we = 1'b0;
      check("ld_ack", ack2, 1);
      check("ld_old", data2, W0);
      rd2 = 1'b0;
      tick();
      read2(30'h0FF8, 32'h0800_0FF8, 1'b0, "ld_new");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
